multi_cycle_ctrl: RTL and testbench

//  Multi-cycle controller for the R-type datapath (pc, Register_file, ALU).

---
 rtl/multi_cycle_ctrl_pkg.sv | 45 ++++
 rtl/multi_cycle_ctrl_funct_decoder.sv | 33 +++
 rtl/multi_cycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl_pkg
//   Shared definitions for the multi-cycle R-type controller: FSM state
//   encodings, the R-type opcode, funct field codes, ALU operation codes and
//   the decoded-funct record produced by the funct decoder.
// -----------------------------------------------------------------------------
package multi_cycle_ctrl_pkg;

   // FSM state encodings (2-bit binary, also exported on o_state)
   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_WB     = 2'd3;

   // Only the R-type opcode is executed by this controller
   localparam logic [5:0] OPCODE_R = 6'b000000;

   // Supported funct codes
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLTU = 6'b101011;
   localparam logic [5:0] FUNCT_SLLV = 6'b000100;

   // ALU operation select codes
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_XOR  = 3'b010;
   localparam logic [2:0] ALU_NOR  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_SUB  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;
   localparam logic [2:0] ALU_SLLV = 3'b111;

   // Result of decoding one funct field
   typedef struct packed {
      logic       valid;     // funct is one of the supported operations
      logic [2:0] alu_op;    // ALU select for the operation
      logic       is_arith;  // add/sub: the only ops that can overflow
   } funct_dec_t;

endpackage

// File: rtl/multi_cycle_ctrl_funct_decoder.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl_funct_decoder
//   Purely combinational map from the R-type funct field to the ALU select.
//   Ports:
//     i_funct  in   6   funct field (inst_code[5:0])
//     o_dec    out  funct_dec_t {valid, alu_op, is_arith}
// -----------------------------------------------------------------------------
module multi_cycle_ctrl_funct_decoder
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [5:0] i_funct,
   output funct_dec_t o_dec
);

   // Decode funct into validity, ALU select and arithmetic class
   always_comb begin
      o_dec.valid    = 1'b1;
      o_dec.alu_op   = ALU_AND;
      o_dec.is_arith = 1'b0;
      case (i_funct)
         FUNCT_ADD:  begin o_dec.alu_op = ALU_ADD; o_dec.is_arith = 1'b1; end
         FUNCT_SUB:  begin o_dec.alu_op = ALU_SUB; o_dec.is_arith = 1'b1; end
         FUNCT_AND:  o_dec.alu_op = ALU_AND;
         FUNCT_OR:   o_dec.alu_op = ALU_OR;
         FUNCT_XOR:  o_dec.alu_op = ALU_XOR;
         FUNCT_NOR:  o_dec.alu_op = ALU_NOR;
         FUNCT_SLTU: o_dec.alu_op = ALU_SLTU;
         FUNCT_SLLV: o_dec.alu_op = ALU_SLLV;
         default:    o_dec.valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
//   Multi-cycle controller for the R-type datapath. Each instruction walks
//   FETCH -> DECODE -> EXEC -> WB; illegal instructions return to FETCH from
//   DECODE. Writeback of add/sub can be suppressed on overflow (OF_TRAP=1).
//   Parameters:
//     CNT_W    width of the retired-instruction counter
//     OF_TRAP  1: suppress o_write_reg on add/sub overflow; 0: always write
//   Ports:
//     i_clk, i_rst              clock, synchronous active-high reset
//     i_mem_ready, i_inst_code  instruction memory handshake / word
//     i_halt                    hold in FETCH
//     i_zf, i_of                ALU zero / overflow flags
//     o_mem_req                 fetch request
//     o_ir_write, o_pc_write    IR load / PC advance pulses (FETCH)
//     o_write_reg               register-file write pulse (WB)
//     o_alu_op                  registered ALU select
//     o_illegal_op              unsupported instruction pulse (DECODE)
//     o_ovf_trap                writeback-suppressed pulse (WB)
//     o_zf_latched              ZF captured in EXEC
//     o_state                   current FSM state
//     o_inst_count              retired instructions
// -----------------------------------------------------------------------------
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter bit OF_TRAP = 1'b1
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_mem_ready,
   input  logic [31:0]      i_inst_code,
   input  logic             i_halt,
   input  logic             i_zf,
   input  logic             i_of,
   output logic             o_mem_req,
   output logic             o_ir_write,
   output logic             o_pc_write,
   output logic             o_write_reg,
   output logic [2:0]       o_alu_op,
   output logic             o_illegal_op,
   output logic             o_ovf_trap,
   output logic             o_zf_latched,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_inst_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [2:0]       r_alu_op;
   logic             r_is_arith;
   logic             r_zf;
   logic             r_ovf;
   logic [CNT_W-1:0] r_count;
   // Decode captured when the IR is loaded, consumed in DECODE
   logic             r_pend_legal;
   logic [2:0]       r_pend_op;
   logic             r_pend_arith;

   funct_dec_t       w_dec;
   logic             w_legal;
   logic             w_fetch_go;
   logic             w_trap;
   logic             w_unused;

   multi_cycle_ctrl_funct_decoder u_funct_decoder (
      .i_funct (i_inst_code[5:0]),
      .o_dec   (w_dec)
   );

   assign w_legal    = w_dec.valid && (i_inst_code[31:26] == OPCODE_R);
   assign w_fetch_go = (r_state == ST_FETCH) && i_mem_ready && !i_halt;
   assign w_trap     = OF_TRAP && r_ovf && r_is_arith;
   // Register/shift fields belong to the datapath, not the controller
   assign w_unused   = ^i_inst_code[25:6];

   // FSM, ALU select, flag capture and retired-instruction counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_FETCH;
         r_alu_op     <= ALU_AND;
         r_is_arith   <= 1'b0;
         r_zf         <= 1'b0;
         r_ovf        <= 1'b0;
         r_count      <= {CNT_W{1'b0}};
         r_pend_legal <= 1'b0;
         r_pend_op    <= ALU_AND;
         r_pend_arith <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               // inst_code is only guaranteed valid alongside mem_ready,
               // so decode is captured here rather than in DECODE
               if (w_fetch_go) begin
                  r_pend_legal <= w_legal;
                  r_pend_op    <= w_dec.alu_op;
                  r_pend_arith <= w_dec.is_arith;
                  r_state      <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (r_pend_legal) begin
                  r_alu_op   <= r_pend_op;
                  r_is_arith <= r_pend_arith;
                  r_state    <= ST_EXEC;
               end else begin
                  r_state    <= ST_FETCH;
               end
            end
            ST_EXEC: begin
               r_zf    <= i_zf;
               r_ovf   <= i_of;
               r_state <= ST_WB;
            end
            ST_WB: begin
               // Trapped instructions still count as retired
               r_count <= r_count + CNT_ONE;
               r_state <= ST_FETCH;
            end
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   // Pulse outputs decoded from the registered state; held low during reset
   always_comb begin
      o_mem_req    = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_write_reg  = 1'b0;
      o_illegal_op = 1'b0;
      o_ovf_trap   = 1'b0;
      if (!i_rst) begin
         case (r_state)
            ST_FETCH: begin
               o_mem_req  = !i_halt;
               o_ir_write = w_fetch_go;
               o_pc_write = w_fetch_go;
            end
            ST_DECODE: o_illegal_op = !r_pend_legal;
            ST_WB: begin
               o_write_reg = !w_trap;
               o_ovf_trap  = w_trap;
            end
            default: o_mem_req = 1'b0;
         endcase
      end else begin
         o_mem_req = 1'b0;
      end
   end

   assign o_alu_op     = r_alu_op;
   assign o_zf_latched = r_zf;
   assign o_state      = r_state;
   assign o_inst_count = r_count;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Directed bench. Two controllers share the stimulus: u_dut uses the
//   defaults (CNT_W=32, OF_TRAP=1), u_dut4 uses CNT_W=4, OF_TRAP=0.
// -----------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ready;
   logic [31:0] inst;
   logic        halt;
   logic        zf;
   logic        of;

   logic        a_mem_req, a_ir_write, a_pc_write, a_write_reg;
   logic [2:0]  a_alu_op;
   logic        a_illegal, a_ovf_trap, a_zf_lat;
   logic [1:0]  a_state;
   logic [31:0] a_count;

   logic        b_mem_req, b_ir_write, b_pc_write, b_write_reg;
   logic [2:0]  b_alu_op;
   logic        b_illegal, b_ovf_trap, b_zf_lat;
   logic [1:0]  b_state;
   logic [3:0]  b_count;

   int          checks   = 0;
   int          failures = 0;
   int          step     = 0;
   logic [31:0] exp_cnt;

   localparam logic [31:0] I_ADD  = 32'h0043_0820;
   localparam logic [31:0] I_SUB  = 32'h0043_0822;
   localparam logic [31:0] I_AND  = 32'h0043_0824;
   localparam logic [31:0] I_OR   = 32'h0043_0825;
   localparam logic [31:0] I_XOR  = 32'h0043_0826;
   localparam logic [31:0] I_NOR  = 32'h0043_0827;
   localparam logic [31:0] I_SLTU = 32'h0043_082B;
   localparam logic [31:0] I_SLLV = 32'h0043_0804;
   localparam logic [31:0] I_LW   = 32'h8C00_0000;
   localparam logic [31:0] I_BADF = 32'h0000_003F;

   always #5 clk = ~clk;

   multi_cycle_ctrl u_dut (
      .i_clk(clk), .i_rst(rst), .i_mem_ready(mem_ready), .i_inst_code(inst),
      .i_halt(halt), .i_zf(zf), .i_of(of),
      .o_mem_req(a_mem_req), .o_ir_write(a_ir_write), .o_pc_write(a_pc_write),
      .o_write_reg(a_write_reg), .o_alu_op(a_alu_op), .o_illegal_op(a_illegal),
      .o_ovf_trap(a_ovf_trap), .o_zf_latched(a_zf_lat), .o_state(a_state),
      .o_inst_count(a_count)
   );

   multi_cycle_ctrl #(.CNT_W(4), .OF_TRAP(1'b0)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_mem_ready(mem_ready), .i_inst_code(inst),
      .i_halt(halt), .i_zf(zf), .i_of(of),
      .o_mem_req(b_mem_req), .o_ir_write(b_ir_write), .o_pc_write(b_pc_write),
      .o_write_reg(b_write_reg), .o_alu_op(b_alu_op), .o_illegal_op(b_illegal),
      .o_ovf_trap(b_ovf_trap), .o_zf_latched(b_zf_lat), .o_state(b_state),
      .o_inst_count(b_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s (step %0d) observed=%0h expected=%0h", tag, step, obs, exp);
      end
   endtask

   // Called at (posedge + small delta) with both DUTs in FETCH.
   task automatic do_instr(input logic [31:0] code, input logic of_v, input logic zf_v,
                           input logic [2:0] exp_op, input logic exp_wr_a, input int waits);
      step++;
      inst = code; halt = 1'b0; mem_ready = 1'b0;
      for (int i = 0; i < waits; i++) begin
         #2;
         chk("wait_state", {30'd0, a_state}, 32'd0);
         chk("wait_mem_req", {31'd0, a_mem_req}, 32'd1);
         chk("wait_pc_write", {31'd0, a_pc_write}, 32'd0);
         @(posedge clk); #1;
      end
      mem_ready = 1'b1; #2;
      chk("fetch_state", {30'd0, a_state}, 32'd0);
      chk("ir_write", {31'd0, a_ir_write}, 32'd1);
      chk("pc_write", {31'd0, a_pc_write}, 32'd1);
      @(posedge clk); #1; mem_ready = 1'b0; #2;
      chk("decode_state", {30'd0, a_state}, 32'd1);
      chk("decode_illegal", {31'd0, a_illegal}, 32'd0);
      chk("decode_ir_write", {31'd0, a_ir_write}, 32'd0);
      @(posedge clk); #1; of = of_v; zf = zf_v; #2;
      chk("exec_state", {30'd0, a_state}, 32'd2);
      chk("exec_alu_op", {29'd0, a_alu_op}, {29'd0, exp_op});
      chk("exec_write_reg", {31'd0, a_write_reg}, 32'd0);
      @(posedge clk); #1; of = 1'b0; zf = 1'b0; #2;
      chk("wb_state", {30'd0, a_state}, 32'd3);
      chk("wb_write_reg", {31'd0, a_write_reg}, {31'd0, exp_wr_a});
      chk("wb_ovf_trap", {31'd0, a_ovf_trap}, {31'd0, !exp_wr_a});
      chk("wb_write_reg_notrap", {31'd0, b_write_reg}, 32'd1);
      chk("wb_ovf_trap_notrap", {31'd0, b_ovf_trap}, 32'd0);
      chk("wb_zf_latched", {31'd0, a_zf_lat}, {31'd0, zf_v});
      chk("wb_alu_op", {29'd0, a_alu_op}, {29'd0, exp_op});
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 32'd1;
      #2;
      chk("retire_state", {30'd0, a_state}, 32'd0);
      chk("retire_write_reg", {31'd0, a_write_reg}, 32'd0);
      chk("count32", a_count, exp_cnt);
      chk("count4", {28'd0, b_count}, {28'd0, exp_cnt[3:0]});
   endtask

   // Illegal instruction: illegal_op in DECODE only, back to FETCH, no retire.
   task automatic do_illegal(input logic [31:0] code, input logic [2:0] prev_op);
      step++;
      inst = code; halt = 1'b0; mem_ready = 1'b1; #2;
      chk("ill_ir_write", {31'd0, a_ir_write}, 32'd1);
      @(posedge clk); #1; mem_ready = 1'b0; #2;
      chk("ill_state", {30'd0, a_state}, 32'd1);
      chk("ill_pulse", {31'd0, a_illegal}, 32'd1);
      chk("ill_pulse4", {31'd0, b_illegal}, 32'd1);
      chk("ill_write_reg", {31'd0, a_write_reg}, 32'd0);
      @(posedge clk); #1; #2;
      chk("ill_next_state", {30'd0, a_state}, 32'd0);
      chk("ill_pulse_gone", {31'd0, a_illegal}, 32'd0);
      chk("ill_write_reg2", {31'd0, a_write_reg}, 32'd0);
      chk("ill_alu_op_kept", {29'd0, a_alu_op}, {29'd0, prev_op});
      chk("ill_count", a_count, exp_cnt);
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b1; inst = I_ADD; halt = 1'b0; zf = 1'b0; of = 1'b0;
      exp_cnt = 32'd0;

      // Reset held two cycles; outputs quiet even with mem_ready high
      repeat (2) @(posedge clk);
      #1; #2;
      chk("rst_state", {30'd0, a_state}, 32'd0);
      chk("rst_ir_write", {31'd0, a_ir_write}, 32'd0);
      chk("rst_alu_op", {29'd0, a_alu_op}, 32'd0);
      chk("rst_zf", {31'd0, a_zf_lat}, 32'd0);
      chk("rst_count", a_count, 32'd0);
      chk("rst_count4", {28'd0, b_count}, 32'd0);
      rst = 1'b0;

      // Basic add, 4-cycle latency; then sub with 3 wait cycles (7 to WB)
      do_instr(I_ADD, 1'b0, 1'b1, 3'b100, 1'b1, 0);
      do_instr(I_SUB, 1'b0, 1'b0, 3'b101, 1'b1, 3);

      // Illegal opcode and illegal funct
      do_illegal(I_LW, 3'b101);
      do_illegal(I_BADF, 3'b101);

      // Overflow handling: trapped sub/add on u_dut, or unaffected
      do_instr(I_SUB, 1'b1, 1'b0, 3'b101, 1'b0, 0);
      do_instr(I_OR,  1'b1, 1'b1, 3'b001, 1'b1, 0);
      do_instr(I_ADD, 1'b1, 1'b0, 3'b100, 1'b0, 1);

      // Remaining funct mappings
      do_instr(I_AND,  1'b0, 1'b1, 3'b000, 1'b1, 0);
      do_instr(I_XOR,  1'b0, 1'b0, 3'b010, 1'b1, 0);
      do_instr(I_NOR,  1'b0, 1'b1, 3'b011, 1'b1, 0);
      do_instr(I_SLTU, 1'b1, 1'b0, 3'b110, 1'b1, 0);
      do_instr(I_SLLV, 1'b0, 1'b0, 3'b111, 1'b1, 0);

      // Reset asserted in EXEC aborts the instruction
      step++;
      inst = I_XOR; mem_ready = 1'b1; #2;
      chk("abort_ir_write", {31'd0, a_ir_write}, 32'd1);
      @(posedge clk); #1; mem_ready = 1'b0; #2;
      chk("abort_decode", {30'd0, a_state}, 32'd1);
      @(posedge clk); #1; rst = 1'b1; #2;
      chk("abort_exec", {30'd0, a_state}, 32'd2);
      chk("abort_exec_wr", {31'd0, a_write_reg}, 32'd0);
      @(posedge clk); #1; #2;
      exp_cnt = 32'd0;
      chk("abort_state", {30'd0, a_state}, 32'd0);
      chk("abort_write_reg", {31'd0, a_write_reg}, 32'd0);
      chk("abort_count", a_count, exp_cnt);
      chk("abort_alu_op", {29'd0, a_alu_op}, 32'd0);
      rst = 1'b0;

      // Halt in FETCH: no request, ready ignored, state held
      step++;
      halt = 1'b1; mem_ready = 1'b1; #2;
      chk("halt_mem_req", {31'd0, a_mem_req}, 32'd0);
      chk("halt_ir_write", {31'd0, a_ir_write}, 32'd0);
      chk("halt_pc_write", {31'd0, a_pc_write}, 32'd0);
      @(posedge clk); #1; #2;
      chk("halt_state", {30'd0, a_state}, 32'd0);
      chk("halt_write_reg", {31'd0, a_write_reg}, 32'd0);
      halt = 1'b0; mem_ready = 1'b0; #2;
      chk("unhalt_mem_req", {31'd0, a_mem_req}, 32'd1);
      chk("unhalt_state", {30'd0, a_state}, 32'd0);
      @(posedge clk); #1;

      // 16 retirements: 4-bit counter wraps 15 -> 0
      for (int n = 0; n < 16; n++) begin
         do_instr(I_ADD, 1'b0, 1'b0, 3'b100, 1'b1, 0);
         if (n == 14) chk("count4_at15", {28'd0, b_count}, 32'd15);
      end
      chk("count4_wrapped", {28'd0, b_count}, 32'd0);
      chk("count32_16", a_count, 32'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
